tl45_operand_fetch: RTL and testbench
=====================================

TL45_OPERAND_FETCH -- requirements
Module: tl45_operand_fetch

Interface
REQ-001 SHALL have port `i_clk`: input, 1 bit, sole clock; all state changes on the rising edge.
REQ-002 SHALL have port `i_reset`: input, 1 bit, asynchronous, active-high reset.
REQ-003 SHALL have ports `i_opcode` (in, 5), `i_dr` (in, 4), `i_sr1` (in, 4), `i_sr2` (in, 4), `i_imm` (in, 32), `i_imm_sel` (in, 1), `i_jmp_cond` (in, 4), `i_pc` (in, 32): the decoded instruction from the decode stage; `i_opcode`=0 is a bubble.
REQ-004 SHALL have ports `i_pipe_stall` and `i_pipe_flush`: in, 1 each, stall and flush requests from the ALU stage.
REQ-005 SHALL have ports `o_pipe_stall` and `o_pipe_flush`: out, 1 each, stall and flush requests to the decode stage.
REQ-006 SHALL have ports `i_of1_reg` (in, 4) and `i_of1_val` (in, 32): same-cycle forward from the ALU stage; reg 0 means none.
REQ-007 SHALL have ports `i_of2_reg` (in, 4) and `i_of2_val` (in, 32): same-cycle forward from the memory stage; reg 0 means none.
REQ-008 SHALL have ports `i_wb_reg` (in, 4) and `i_wb_val` (in, 32): writeback port; reg 0 means no write.
REQ-009 SHALL have registered outputs `o_opcode` (5), `o_dr` (4), `o_jmp_cond` (4), `o_sr1_val` (32), `o_sr2_val` (32), `o_target_offset` (32), `o_pc` (32), all driving the ALU stage.

Function
REQ-010 SHALL hold 16 architectural registers; r0 SHALL always read 0 and writes to it SHALL be ignored.
REQ-011 SHALL write `i_wb_val` into register `i_wb_reg` on every rising edge where `i_wb_reg` != 0, regardless of stall or flush.
REQ-012 SHALL resolve each source operand in this priority order:
- index 0 -> 0
- match `i_of1_reg` -> `i_of1_val`
- match `i_of2_reg` -> `i_of2_val`
- match `i_wb_reg` -> `i_wb_val` (write-through)
- otherwise the register-file value.
REQ-013 SHALL compute operand values as follows:
- sr1 value = resolved `i_sr1`.
- sr2 value = `i_imm` when `i_imm_sel`=1, else resolved `i_sr2`.
- target offset = `i_imm`.
REQ-014 SHALL drive `o_pipe_flush` = `i_pipe_flush` combinationally.
REQ-015 SHALL drive `o_pipe_stall` = `i_pipe_stall` OR `load_use`.
REQ-016 SHALL define `load_use` as all of the following being true:
- `o_opcode` == OP_LW
- `o_dr` != 0
- `o_dr` equals a source register that `i_opcode` actually reads (`i_sr1`, or `i_sr2` when `i_imm_sel`=0)
- `i_opcode` != 0.
REQ-017 SHALL update the output register with this priority at each edge:
- flush -> all outputs 0
- else `i_pipe_stall` -> hold all outputs
- else `load_use` -> all outputs 0 (bubble); decode holds its instruction
- else capture the resolved instruction.
REQ-018 SHALL have a latency of 1 cycle from decode input to ALU output when there is no hazard.
REQ-019 SHALL cost exactly one bubble cycle for a load-use hazard; in the following cycle the operand SHALL come from the `i_of2` forward.
REQ-020 SHALL give flush priority over stall when both are asserted in the same cycle.
REQ-021 SHALL NOT re-resolve operands while held; the held values SHALL remain valid because the ALU instruction is frozen.

Reset
REQ-022 SHALL, on `i_reset` assertion, immediately clear every output register and every register-file entry to 0.
REQ-023 SHALL, when reset is asserted mid-stall, drop the stalled instruction and resume capture on the first edge after deassertion.

Structure
REQ-024 SHALL take OP_LW = 5'h14, the other opcodes, and the register-index width from shared package `tl45_pkg`.
REQ-025 SHALL implement the register file in sub-module `tl45_regfile`: 2 combinational read ports, 1 synchronous write port, asynchronous clear.

Verification
REQ-026 SHALL verify write-through:
- Stimulus: wb r3=0x11, with decode `add r4,r3,r3` in the same cycle.
- Response: next cycle `o_sr1_val` = `o_sr2_val` = 0x11.
REQ-027 SHALL verify forward priority:
- Stimulus: `i_of1_reg`=5/0xA, `i_of2_reg`=5/0xB, register r5=0xC, with sr1=5.
- Response: `o_sr1_val`=0xA.
REQ-028 SHALL verify the load-use bubble:
- Stimulus: `lw r2` in the ALU stage, then `add r1,r2,r0`.
- Response: `o_pipe_stall`=1 for one cycle and the outputs are 0; the next cycle `o_sr1_val` = `i_of2_val` (0x55).
REQ-029 SHALL verify the stall hold:
- Stimulus: `i_pipe_stall`=1 for 3 cycles.
- Response: outputs are constant; `o_pipe_stall`=1 for those 3 cycles.
REQ-030 SHALL verify flush over stall:
- Stimulus: `i_pipe_flush`=`i_pipe_stall`=1.
- Response: next cycle all outputs are 0 and `o_pipe_flush`=1 in the same cycle.
REQ-031 SHALL verify r0 handling:
- Stimulus: wb r0=0xFFFF followed by a read of r0, and reset asserted mid-operation.
- Response: the read returns 0; all outputs are 0 asynchronously on reset.

Source files
------------

// File: rtl/tl45_pkg.sv
// Shared TL45 pipeline definitions: field widths, opcodes, the operand-fetch
// output payload and the operand forwarding resolver.
package tl45_pkg;

    localparam int unsigned REG_W    = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OPC_W    = 5;
    localparam int unsigned COND_W   = 4;
    localparam int unsigned NUM_REGS = 16;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [OPC_W-1:0]  opcode_t;
    typedef logic [COND_W-1:0] cond_t;

    localparam opcode_t OP_NOP = 5'h00;
    localparam opcode_t OP_ADD = 5'h01;
    localparam opcode_t OP_SUB = 5'h02;
    localparam opcode_t OP_AND = 5'h03;
    localparam opcode_t OP_OR  = 5'h04;
    localparam opcode_t OP_XOR = 5'h05;
    localparam opcode_t OP_JMP = 5'h0C;
    localparam opcode_t OP_LW  = 5'h14;
    localparam opcode_t OP_SW  = 5'h15;

    typedef struct packed {
        opcode_t  opcode;
        reg_idx_t dr;
        cond_t    jmp_cond;
        word_t    sr1_val;
        word_t    sr2_val;
        word_t    target_offset;
        word_t    pc;
    } of_out_t;

    // Youngest producer wins: ALU forward, then memory forward, then writeback.
    function automatic word_t resolve_operand(
        input reg_idx_t idx,
        input reg_idx_t of1_reg, input word_t of1_val,
        input reg_idx_t of2_reg, input word_t of2_val,
        input reg_idx_t wb_reg,  input word_t wb_val,
        input word_t    rf_val
    );
        word_t val;
        if (idx == '0)               val = '0;
        else if (idx == of1_reg)     val = of1_val;
        else if (idx == of2_reg)     val = of2_val;
        else if (idx == wb_reg)      val = wb_val;
        else                         val = rf_val;
        return val;
    endfunction

endpackage

// File: rtl/tl45_operand_fetch_if.sv
// Operand-fetch stage bus: decoded instruction, forwards, writeback,
// pipeline control and the registered ALU-side outputs.
interface tl45_operand_fetch_if;
    import tl45_pkg::*;

    opcode_t  i_opcode;
    reg_idx_t i_dr;
    reg_idx_t i_sr1;
    reg_idx_t i_sr2;
    word_t    i_imm;
    logic     i_imm_sel;
    cond_t    i_jmp_cond;
    word_t    i_pc;

    logic     i_pipe_stall;
    logic     i_pipe_flush;
    logic     o_pipe_stall;
    logic     o_pipe_flush;

    reg_idx_t i_of1_reg;
    word_t    i_of1_val;
    reg_idx_t i_of2_reg;
    word_t    i_of2_val;
    reg_idx_t i_wb_reg;
    word_t    i_wb_val;

    opcode_t  o_opcode;
    reg_idx_t o_dr;
    cond_t    o_jmp_cond;
    word_t    o_sr1_val;
    word_t    o_sr2_val;
    word_t    o_target_offset;
    word_t    o_pc;

    modport master (
        output i_opcode, i_dr, i_sr1, i_sr2, i_imm, i_imm_sel, i_jmp_cond, i_pc,
        output i_pipe_stall, i_pipe_flush,
        output i_of1_reg, i_of1_val, i_of2_reg, i_of2_val, i_wb_reg, i_wb_val,
        input  o_pipe_stall, o_pipe_flush,
        input  o_opcode, o_dr, o_jmp_cond, o_sr1_val, o_sr2_val, o_target_offset, o_pc
    );

    modport slave (
        input  i_opcode, i_dr, i_sr1, i_sr2, i_imm, i_imm_sel, i_jmp_cond, i_pc,
        input  i_pipe_stall, i_pipe_flush,
        input  i_of1_reg, i_of1_val, i_of2_reg, i_of2_val, i_wb_reg, i_wb_val,
        output o_pipe_stall, o_pipe_flush,
        output o_opcode, o_dr, o_jmp_cond, o_sr1_val, o_sr2_val, o_target_offset, o_pc
    );

endinterface

// File: rtl/tl45_regfile.sv
// 16 x 32 architectural register file: two combinational reads, one
// synchronous write, asynchronous clear. r0 is never written and reads 0.
module tl45_regfile
    import tl45_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    input  reg_idx_t i_ra1,
    input  reg_idx_t i_ra2,
    output word_t    o_rd1,
    output word_t    o_rd2,
    input  reg_idx_t i_wr_reg,
    input  word_t    i_wr_val
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (i_wr_reg != '0) regs_d[i_wr_reg] = i_wr_val;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) regs_q <= '{default: '0};
        else         regs_q <= regs_d;
    end

    assign o_rd1 = (i_ra1 == '0) ? '0 : regs_q[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : regs_q[i_ra2];

endmodule

// File: rtl/tl45_operand_fetch.sv
// TL45 operand-fetch stage: reads/forwards source operands, detects load-use
// hazards and registers the resolved instruction for the ALU stage.
module tl45_operand_fetch
    import tl45_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    tl45_operand_fetch_if.slave   bus
);

    word_t   rf_rd1;
    word_t   rf_rd2;
    word_t   sr1_val_c;
    word_t   sr2_val_c;
    logic    load_use_c;
    of_out_t capture_c;
    of_out_t out_d;
    of_out_t out_q;

    tl45_regfile u_regfile (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_ra1    (bus.i_sr1),
        .i_ra2    (bus.i_sr2),
        .o_rd1    (rf_rd1),
        .o_rd2    (rf_rd2),
        .i_wr_reg (bus.i_wb_reg),
        .i_wr_val (bus.i_wb_val)
    );

    // Operand resolution; sr2 is replaced by the immediate when selected.
    always_comb begin
        sr1_val_c = resolve_operand(bus.i_sr1, bus.i_of1_reg, bus.i_of1_val,
                                    bus.i_of2_reg, bus.i_of2_val,
                                    bus.i_wb_reg, bus.i_wb_val, rf_rd1);
        sr2_val_c = bus.i_imm_sel ? bus.i_imm
                  : resolve_operand(bus.i_sr2, bus.i_of1_reg, bus.i_of1_val,
                                    bus.i_of2_reg, bus.i_of2_val,
                                    bus.i_wb_reg, bus.i_wb_val, rf_rd2);
    end

    // A load in the ALU stage cannot forward until it reaches memory.
    always_comb begin
        load_use_c = 1'b0;
        if ((out_q.opcode == OP_LW) && (out_q.dr != '0) && (bus.i_opcode != OP_NOP)) begin
            load_use_c = (out_q.dr == bus.i_sr1) ||
                         (!bus.i_imm_sel && (out_q.dr == bus.i_sr2));
        end
    end

    always_comb begin
        capture_c               = '0;
        capture_c.opcode        = bus.i_opcode;
        capture_c.dr            = bus.i_dr;
        capture_c.jmp_cond      = bus.i_jmp_cond;
        capture_c.sr1_val       = sr1_val_c;
        capture_c.sr2_val       = sr2_val_c;
        capture_c.target_offset = bus.i_imm;
        capture_c.pc            = bus.i_pc;
    end

    // Flush beats stall; a load-use hazard inserts a bubble.
    always_comb begin
        out_d = out_q;
        if (bus.i_pipe_flush)      out_d = '0;
        else if (bus.i_pipe_stall) out_d = out_q;
        else if (load_use_c)       out_d = '0;
        else                       out_d = capture_c;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) out_q <= '0;
        else         out_q <= out_d;
    end

    assign bus.o_pipe_flush    = bus.i_pipe_flush;
    assign bus.o_pipe_stall    = bus.i_pipe_stall | load_use_c;
    assign bus.o_opcode        = out_q.opcode;
    assign bus.o_dr            = out_q.dr;
    assign bus.o_jmp_cond      = out_q.jmp_cond;
    assign bus.o_sr1_val       = out_q.sr1_val;
    assign bus.o_sr2_val       = out_q.sr2_val;
    assign bus.o_target_offset = out_q.target_offset;
    assign bus.o_pc            = out_q.pc;

endmodule

// File: tb/tb_tl45_operand_fetch.sv
// Scoreboard bench for tl45_operand_fetch: directed hazard/forward/reset cases
// plus random traffic checked against a behavioural pipeline-stage model.
module tb_tl45_operand_fetch;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [3:0]  dr;
        logic [3:0]  sr1;
        logic [3:0]  sr2;
        logic [31:0] imm;
        logic        imm_sel;
        logic [3:0]  jmp;
        logic [31:0] pc;
        logic        pstall;
        logic        pflush;
        logic [3:0]  of1r;
        logic [31:0] of1v;
        logic [3:0]  of2r;
        logic [31:0] of2v;
        logic [3:0]  wbr;
        logic [31:0] wbv;
    } stim_t;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [3:0]  dr;
        logic [3:0]  jmp;
        logic [31:0] sr1;
        logic [31:0] sr2;
        logic [31:0] off;
        logic [31:0] pc;
    } exp_out_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } exp_ctl_t;

    localparam logic [4:0] LW  = 5'h14;
    localparam logic [4:0] ADD = 5'h01;
    localparam logic [4:0] SUB = 5'h02;

    logic clk;
    logic rst;
    tl45_operand_fetch_if bus_if ();

    tl45_operand_fetch dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_if)
    );

    int total = 0;
    int bad   = 0;

    exp_out_t    out_q[$];
    exp_ctl_t    ctl_q[$];
    exp_out_t    mo;
    logic [31:0] mregs [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input stim_t s, input logic [3:0] r);
        if (r == 4'd0)      return 32'd0;
        if (r == s.of1r)    return s.of1v;
        if (r == s.of2r)    return s.of2v;
        if (r == s.wbr)     return s.wbv;
        return mregs[r];
    endfunction

    // Behavioural stage: what the ALU sees after the coming edge.
    task automatic model_step(input stim_t s);
        logic     lu;
        exp_out_t cap;
        exp_out_t nx;
        lu = (mo.opcode == LW) && (mo.dr != 4'd0) && (s.opcode != 5'd0) &&
             ((mo.dr == s.sr1) || (!s.imm_sel && (mo.dr == s.sr2)));
        ctl_q.push_back('{stall: s.pstall | lu, flush: s.pflush});
        cap = '{opcode: s.opcode, dr: s.dr, jmp: s.jmp,
                sr1: model_read(s, s.sr1),
                sr2: s.imm_sel ? s.imm : model_read(s, s.sr2),
                off: s.imm, pc: s.pc};
        if (s.pflush)      nx = '0;
        else if (s.pstall) nx = mo;
        else if (lu)       nx = '0;
        else               nx = cap;
        out_q.push_back(nx);
        mo = nx;
        if (s.wbr != 4'd0) mregs[s.wbr] = s.wbv;
    endtask

    task automatic apply(input stim_t s);
        bus_if.i_opcode     = s.opcode;
        bus_if.i_dr         = s.dr;
        bus_if.i_sr1        = s.sr1;
        bus_if.i_sr2        = s.sr2;
        bus_if.i_imm        = s.imm;
        bus_if.i_imm_sel    = s.imm_sel;
        bus_if.i_jmp_cond   = s.jmp;
        bus_if.i_pc         = s.pc;
        bus_if.i_pipe_stall = s.pstall;
        bus_if.i_pipe_flush = s.pflush;
        bus_if.i_of1_reg    = s.of1r;
        bus_if.i_of1_val    = s.of1v;
        bus_if.i_of2_reg    = s.of2r;
        bus_if.i_of2_val    = s.of2v;
        bus_if.i_wb_reg     = s.wbr;
        bus_if.i_wb_val     = s.wbv;
    endtask

    task automatic issue(input stim_t s, input bit wait_edge);
        if (wait_edge) @(negedge clk);
        apply(s);
        #1;
        model_step(s);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_opcode"}, 32'(bus_if.o_opcode), 32'd0);
        chk({tag, "_dr"},     32'(bus_if.o_dr), 32'd0);
        chk({tag, "_jmp"},    32'(bus_if.o_jmp_cond), 32'd0);
        chk({tag, "_sr1"},    bus_if.o_sr1_val, 32'd0);
        chk({tag, "_sr2"},    bus_if.o_sr2_val, 32'd0);
        chk({tag, "_off"},    bus_if.o_target_offset, 32'd0);
        chk({tag, "_pc"},     bus_if.o_pc, 32'd0);
    endtask

    // Asserts reset part-way through the current cycle; caller issues next.
    task automatic reset_midcycle(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero(tag);
        out_q.delete();
        mo = '0;
        for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s = '0;
        case ($urandom_range(0, 5))
            0:       s.opcode = 5'd0;
            1, 2:    s.opcode = LW;
            3:       s.opcode = SUB;
            default: s.opcode = ADD;
        endcase
        s.dr      = 4'($urandom_range(0, 5));
        s.sr1     = 4'($urandom_range(0, 5));
        s.sr2     = 4'($urandom_range(0, 5));
        s.imm     = $urandom;
        s.imm_sel = ($urandom_range(0, 3) == 0);
        s.jmp     = 4'($urandom_range(0, 15));
        s.pc      = $urandom;
        s.pstall  = ($urandom_range(0, 5) == 0);
        s.pflush  = ($urandom_range(0, 11) == 0);
        s.of1r    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 5)) : 4'd0;
        s.of1v    = $urandom;
        s.of2r    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 5)) : 4'd0;
        s.of2v    = $urandom;
        s.wbr     = 4'($urandom_range(0, 5));
        s.wbv     = $urandom;
        return s;
    endfunction

    // Registered-output monitor.
    always begin
        exp_out_t e;
        @(posedge clk);
        #1;
        if (out_q.size() > 0) begin
            e = out_q.pop_front();
            chk("sb_opcode", 32'(bus_if.o_opcode), 32'(e.opcode));
            chk("sb_dr",     32'(bus_if.o_dr), 32'(e.dr));
            chk("sb_jmp",    32'(bus_if.o_jmp_cond), 32'(e.jmp));
            chk("sb_sr1",    bus_if.o_sr1_val, e.sr1);
            chk("sb_sr2",    bus_if.o_sr2_val, e.sr2);
            chk("sb_off",    bus_if.o_target_offset, e.off);
            chk("sb_pc",     bus_if.o_pc, e.pc);
        end
    end

    // Combinational stall/flush monitor.
    always begin
        exp_ctl_t c;
        @(negedge clk);
        #2;
        if (ctl_q.size() > 0) begin
            c = ctl_q.pop_front();
            chk("sb_pipe_stall", 32'(bus_if.o_pipe_stall), 32'(c.stall));
            chk("sb_pipe_flush", 32'(bus_if.o_pipe_flush), 32'(c.flush));
        end
    end

    initial begin
        stim_t z;
        stim_t s;
        z  = '0;
        mo = '0;
        for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
        rst = 1'b1;
        apply(z);
        #3;
        chk_outputs_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
        issue(z, 0);

        // Writeback write-through into a same-cycle read.
        s = z; s.wbr = 4'd3; s.wbv = 32'h11;
        s.opcode = ADD; s.dr = 4'd4; s.sr1 = 4'd3; s.sr2 = 4'd3;
        issue(s, 1);
        @(posedge clk); #2;
        chk("wt_sr1", bus_if.o_sr1_val, 32'h11);
        chk("wt_sr2", bus_if.o_sr2_val, 32'h11);

        // Forward priority: ALU over memory over writeback over register file.
        s = z; s.wbr = 4'd5; s.wbv = 32'hC;
        issue(s, 1);
        s = z; s.opcode = ADD; s.dr = 4'd6; s.sr1 = 4'd5;
        s.of1r = 4'd5; s.of1v = 32'hA; s.of2r = 4'd5; s.of2v = 32'hB;
        issue(s, 1);
        @(posedge clk); #2;
        chk("fwd_of1", bus_if.o_sr1_val, 32'hA);
        s = z; s.opcode = ADD; s.dr = 4'd6; s.sr1 = 4'd5;
        s.of2r = 4'd5; s.of2v = 32'hB; s.wbr = 4'd5; s.wbv = 32'hD;
        issue(s, 1);
        @(posedge clk); #2;
        chk("fwd_of2", bus_if.o_sr1_val, 32'hB);
        s = z; s.opcode = ADD; s.dr = 4'd6; s.sr1 = 4'd5;
        issue(s, 1);
        @(posedge clk); #2;
        chk("rf_read", bus_if.o_sr1_val, 32'hD);

        // Load-use: one bubble, then the operand arrives on the memory forward.
        s = z; s.opcode = LW; s.dr = 4'd2; s.imm = 32'd4; s.imm_sel = 1'b1;
        issue(s, 1);
        s = z; s.opcode = ADD; s.dr = 4'd1; s.sr1 = 4'd2; s.sr2 = 4'd0;
        issue(s, 1);
        #1;
        chk("lu_stall", 32'(bus_if.o_pipe_stall), 32'd1);
        @(posedge clk); #2;
        chk("lu_bubble_opcode", 32'(bus_if.o_opcode), 32'd0);
        chk("lu_bubble_sr1", bus_if.o_sr1_val, 32'd0);
        s.of2r = 4'd2; s.of2v = 32'h55;
        issue(s, 1);
        #1;
        chk("lu_stall_clear", 32'(bus_if.o_pipe_stall), 32'd0);
        @(posedge clk); #2;
        chk("lu_fwd_sr1", bus_if.o_sr1_val, 32'h55);
        chk("lu_fwd_opcode", 32'(bus_if.o_opcode), 32'(ADD));

        // Stall hold for three cycles.
        s = z; s.opcode = ADD; s.dr = 4'd7; s.imm = 32'h1234; s.imm_sel = 1'b1; s.pc = 32'h100;
        issue(s, 1);
        for (int k = 0; k < 3; k++) begin
            s = rand_stim(); s.pstall = 1'b1; s.pflush = 1'b0;
            issue(s, 1);
            #1;
            chk("hold_stall", 32'(bus_if.o_pipe_stall), 32'd1);
            @(posedge clk); #2;
            chk("hold_pc", bus_if.o_pc, 32'h100);
            chk("hold_sr2", bus_if.o_sr2_val, 32'h1234);
            chk("hold_dr", 32'(bus_if.o_dr), 32'd7);
        end

        // Flush wins over stall.
        s = z; s.opcode = ADD; s.dr = 4'd3; s.pc = 32'h44; s.pstall = 1'b1; s.pflush = 1'b1;
        issue(s, 1);
        #1;
        chk("flush_out", 32'(bus_if.o_pipe_flush), 32'd1);
        @(posedge clk); #2;
        chk_outputs_zero("flush");

        // r0 ignores writes and always reads zero.
        s = z; s.wbr = 4'd0; s.wbv = 32'hFFFF;
        issue(s, 1);
        s = z; s.opcode = ADD; s.dr = 4'd3; s.wbv = 32'hFFFF;
        issue(s, 1);
        @(posedge clk); #2;
        chk("r0_sr1", bus_if.o_sr1_val, 32'd0);
        chk("r0_sr2", bus_if.o_sr2_val, 32'd0);

        // Reset during a stall drops the held instruction and clears registers.
        s = z; s.opcode = ADD; s.dr = 4'd8; s.pc = 32'h200; s.imm = 32'd7; s.imm_sel = 1'b1;
        issue(s, 1);
        s = z; s.pstall = 1'b1;
        issue(s, 1);
        reset_midcycle("rst_mid");
        s = z; s.opcode = ADD; s.dr = 4'd9; s.sr1 = 4'd5; s.pc = 32'h300;
        issue(s, 0);
        @(posedge clk); #2;
        chk("post_rst_pc", bus_if.o_pc, 32'h300);
        chk("post_rst_dr", 32'(bus_if.o_dr), 32'd9);
        chk("post_rst_r5", bus_if.o_sr1_val, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            issue(rand_stim(), 1);
            if (n == 200) begin
                reset_midcycle("rst_rand");
                issue(rand_stim(), 0);
            end
        end

        issue(z, 1);
        issue(z, 1);
        @(posedge clk); #3;
        chk("queue_drain", 32'(out_q.size() + ctl_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
